sram_port_ctrl: RTL
===================

# sram_port_ctrl

Initiator-side controller for one `sky130_sram_2kbyte_1rw1r_32x512` macro (512 x 32, byte write mask). It zero-initializes the macro after reset. It then converts a valid/ready request stream into macro port-0 accesses and returns read data through a small response FIFO with full backpressure support. It sits between a core-side memory client (cache refill, scratchpad) and the macro instance; port 1 is parked inactive.

## Interface

- `ADDR_WIDTH`, 9: word address width; macro depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32: data width; byte mask width = DATA_WIDTH/8.
- `INIT_EN`, 1: 1 = zero-fill the macro after reset; 0 = go straight to RUN.
- `RESP_DEPTH`, 3: response FIFO entries; minimum 3 for full read throughput.

Ports:

- `clk` in 1: single clock. Also drives `sram_clk0` and `sram_clk1`.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_wmask` in 4: byte enables. Bit i covers bits [8i+7:8i].
- `req_addr` in 9: word address.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: read data available.
- `resp_ready` in 1: response consumed when `resp_valid && resp_ready`.
- `resp_rdata` out 32: read data.
- `init_done` out 1: high once the zero-fill is complete.
- `sram_clk0`, `sram_csb0`, `sram_web0` out 1 each: macro port-0 clock, chip select (active low), write enable (active low).
- `sram_wmask0` out 4, `sram_addr0` out 9, `sram_din0` out 32: macro port-0 write mask, address, write data.
- `sram_dout0` in 32: macro port-0 read data.
- `sram_clk1`, `sram_csb1` out 1 each: macro port-1 clock and chip select.
- `sram_addr1` out 9: macro port-1 address.
- `sram_dout1` in 32: macro port-1 read data; unused.

## Operation

- The FSM has two states, INIT and RUN.
  - While reset is asserted the FSM enters INIT (or RUN if INIT_EN=0).
  - The init counter, FIFO, and in-flight flag are all cleared by reset.
- INIT:
  - Each cycle drive `csb0=0`, `web0=0`, `wmask0=4'hF`, `din0=0`, and `addr0` = counter.
  - The counter increments each cycle.
  - After the write to address 511 the FSM moves to RUN, and `init_done` goes to 1 on the next cycle.
  - `req_ready` is 0 throughout INIT.
- RUN:
  - `req_ready = (fifo_count + inflight) < RESP_DEPTH`. It does not depend combinationally on `resp_ready`.
  - An accepted request drives the macro pins combinationally in the same cycle: `csb0=0`, `web0=~req_wen`, `wmask0=req_wmask`, `addr0=req_addr`, `din0=req_wdata`.
  - With no accepted request, `csb0=1` and the other macro inputs are don't-care.
  - A write produces no response. `wmask0=0` is a legal write and leaves memory unchanged.
- Read handling:
  - An accepted read sets `inflight` for the next cycle.
  - At the end of that next cycle, `sram_dout0` is pushed into the FIFO.
  - `sram_dout0` is never captured after a write.
- Response FIFO:
  - FIFO order; `resp_valid = fifo_count != 0`; `resp_rdata` = head entry.
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - Overflow cannot occur, because of the `req_ready` rule.
- Port 1 is parked: `sram_csb1=1`, `sram_addr1=0`.
- Reset values:
  - `req_ready=0`, `resp_valid=0`, `init_done=0`.
  - `sram_csb0=1`, `sram_web0=1`, `sram_csb1=1`.
- Reset asserted mid-operation: FIFO contents and in-flight reads are discarded, and INIT restarts at address 0.

## Timing

- Read latency: request accepted in cycle N, `resp_valid` high in cycle N+2 (if the FIFO was empty).
- Throughput: with `resp_ready` held 1, one read or write is accepted every cycle indefinitely.
- Backpressure: with `resp_ready=0`, at most RESP_DEPTH reads are outstanding; `req_ready` falls once that limit is reached.
- Init duration: `init_done` rises 513 cycles after the first cycle with `rst_n=1`.
- Macro port 0 samples its inputs at the `clk` rising edge. `sram_dout0` is valid during the following cycle.

## Test plan

- Init: release `rst_n` and check 512 consecutive cycles of `csb0=0`, `web0=0`, `din0=0`, with `addr0` running 0 to 511. `init_done` must rise at cycle 513, with `req_ready=0` before that. Reading address 300 afterwards must return 0x00000000.
- Write then read: write 0xDEADBEEF to address 5 with mask 4'hF, then read address 5. `resp_rdata` must be 0xDEADBEEF with `resp_valid` high exactly 2 cycles after the read is accepted.
- Byte mask: over 0xDEADBEEF at address 5, write 0x11223344 with mask 4'b0101. A read must return 0xDE22BE44.
- Backpressure: hold `resp_ready=0` and offer 5 reads of addresses 1 to 5 (holding the values written earlier). Exactly 3 must be accepted before `req_ready=0`. Raising `resp_ready` must return addresses 1, 2, 3 in order, after which the remaining reads are accepted.
- Streaming: with `resp_ready=1`, issue 8 back-to-back reads of addresses 10 to 17. All must be accepted in 8 consecutive cycles, with 8 contiguous responses in order.
- Reset mid-operation: assert `rst_n=0` with 2 FIFO entries and 1 read in flight. In the next cycle `resp_valid=0` and `init_done=0`, and after release INIT restarts at `addr0=0`.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Port-0 initiator for a 1rw1r SRAM macro: zero-fills the array after reset, then
// turns a valid/ready request stream into macro accesses with a small read-response FIFO.
module sram_port_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int INIT_EN    = 1,
    parameter int RESP_DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    init_done,
    output logic                    sram_clk0,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [DATA_WIDTH/8-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0,
    output logic                    sram_clk1,
    output logic                    sram_csb1,
    output logic [ADDR_WIDTH-1:0]   sram_addr1,
    input  logic [DATA_WIDTH-1:0]   sram_dout1
);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];

    logic [CNT_W:0]        occupancy;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  unused_dout1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Reads in flight count against FIFO space so a returning read always has a slot.
    assign occupancy  = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    assign req_ready  = rst_n && init_done_q && (occupancy < (CNT_W + 1)'(RESP_DEPTH));
    assign accept     = req_valid && req_ready;
    assign push       = inflight_q;
    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_rdata = fifo_q[rd_ptr_q];
    assign init_done  = init_done_q;

    assign sram_clk0    = clk;
    assign sram_clk1    = clk;
    assign sram_csb1    = 1'b1;
    assign sram_addr1   = '0;
    assign unused_dout1 = ^sram_dout1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_RUN;
            end
        end else begin
            init_done_d = 1'b1;
        end
    end

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = req_wmask;
        sram_addr0  = req_addr;
        sram_din0   = req_wdata;
        if (rst_n && state_q == ST_INIT) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = cnt_q;
            sram_din0   = '0;
        end else if (accept) begin
            sram_csb0 = 1'b0;
            sram_web0 = ~req_wen;
        end
    end

    always_comb begin
        inflight_d = accept && !req_wen;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Macro read data is valid the cycle after the access, which is when inflight_q is set.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sram_dout0;
        end
    end
endmodule
